// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Single arbiter for a two-way (NS/EW) intersection. It sequences
// green -> yellow -> all-red for each direction in turn, never lets both
// directions show non-red, and latches pedestrian requests so they are
// served with a walk lamp during the opposite green.
//
// Optional build macro: SCHED_PED_PREEMPT_EN
//   defined   - a pending request in the green direction ends that green
//               early, once it has run at least GREEN_MIN ticks.
//   undefined - greens always run GREEN_MAX ticks; requests are still
//               latched, displayed and served.
module intersection_phase_scheduler #(
   parameter int unsigned GREEN_MAX   = 20,
   parameter int unsigned GREEN_MIN   = 5,
   parameter int unsigned YELLOW_TIME = 3,
   parameter int unsigned ALLRED_TIME = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_NS,
   input  logic       ped_EW,
   output logic       NS_red,
   output logic       NS_yellow,
   output logic       NS_green,
   output logic       EW_red,
   output logic       EW_yellow,
   output logic       EW_green,
   output logic       walk_NS,
   output logic       walk_EW,
   output logic       ped_wait_NS,
   output logic       ped_wait_EW,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      AR_A   = 3'd2,
      EW_GRN = 3'd3,
      EW_YEL = 3'd4,
      AR_B   = 3'd5
   } phase_t;

   // Final count value of each phase timer (the timer runs 0 .. dur-1)
   localparam logic [7:0] GREEN_LAST  = 8'(GREEN_MAX - 1);
   localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
   localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);

   // Kept as a plain vector so that the unused codes 6 and 7 are
   // representable and can be recovered from.
   logic [2:0] state;
   phase_t     state_nxt;
   logic [7:0] cnt;
   logic [7:0] cnt_nxt;

   logic       state_legal;
   logic       cnt_last;
   logic       preempt;
   logic       advance;

   logic       ped_pend_NS;
   logic       ped_pend_EW;
   logic       served_NS;
   logic       served_EW;
   logic       blink;

   logic       ns_active;
   logic       ew_active;
   logic       clear_ns;
   logic       clear_ew;

   assign state_legal = (state <= 3'd5);

   // Flag the last count of the current phase so the next tick can leave it
   always_comb begin
      cnt_last = 1'b0;
      case (state)
         NS_GRN, EW_GRN: cnt_last = (cnt == GREEN_LAST);
         NS_YEL, EW_YEL: cnt_last = (cnt == YELLOW_LAST);
         AR_A, AR_B:     cnt_last = (cnt == ALLRED_LAST);
         default:        cnt_last = 1'b0;
      endcase
   end

`ifdef SCHED_PED_PREEMPT_EN
   localparam logic [7:0] GREEN_MIN_LAST = 8'(GREEN_MIN - 1);

   // A request waiting in the direction that currently has green may cut
   // that green short once the minimum green time has elapsed.
   assign preempt = (((state == NS_GRN) && ped_pend_NS) ||
                     ((state == EW_GRN) && ped_pend_EW)) &&
                    (cnt >= GREEN_MIN_LAST);
`else
   assign preempt = 1'b0;
`endif

   // preempt is only ever high in a green state, so it cannot shorten
   // yellow or all-red.
   assign advance = tick & (cnt_last | preempt);

   // Next phase in the fixed rotation; illegal codes recover into AR_B
   always_comb begin
      state_nxt = AR_B;
      case (state)
         NS_GRN:  state_nxt = advance ? NS_YEL : NS_GRN;
         NS_YEL:  state_nxt = advance ? AR_A   : NS_YEL;
         AR_A:    state_nxt = advance ? EW_GRN : AR_A;
         EW_GRN:  state_nxt = advance ? EW_YEL : EW_GRN;
         EW_YEL:  state_nxt = advance ? AR_B   : EW_YEL;
         AR_B:    state_nxt = advance ? NS_GRN : AR_B;
         default: state_nxt = AR_B;
      endcase
   end

   // Phase timer: zero on every phase entry, count ticks otherwise, and
   // hold at full scale rather than wrap.
   always_comb begin
      cnt_nxt = cnt;
      if (advance || !state_legal) begin
         cnt_nxt = 8'd0;
      end else if (tick && (cnt != 8'hFF)) begin
         cnt_nxt = cnt + 8'd1;
      end
   end

   // Phase register, phase timer and the wait-lamp blink divider
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= NS_GRN;
         cnt   <= 8'd0;
         blink <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         blink <= blink ^ tick;
      end
   end

   // A direction may register a request only while it is green or yellow;
   // while it is red its crossing is already walkable.
   assign ns_active = (state == NS_GRN) || (state == NS_YEL);
   assign ew_active = (state == EW_GRN) || (state == EW_YEL);

   // Entry into the all-red that follows a direction's yellow
   assign clear_ns  = (state == NS_YEL) && advance;
   assign clear_ew  = (state == EW_YEL) && advance;

   // Pending requests and the served flags captured when they are retired.
   // A request arriving on the very clock that retires the previous one
   // wins over the clear and stays pending for the next round.
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pend_NS <= 1'b0;
         ped_pend_EW <= 1'b0;
         served_NS   <= 1'b0;
         served_EW   <= 1'b0;
      end else begin
         ped_pend_NS <= (ped_NS && ns_active) || (ped_pend_NS && !clear_ns);
         ped_pend_EW <= (ped_EW && ew_active) || (ped_pend_EW && !clear_ew);
         if (clear_ns) begin
            served_NS <= ped_pend_NS;
         end
         if (clear_ew) begin
            served_EW <= ped_pend_EW;
         end
      end
   end

   // Lamp decode straight from the phase register; anything that is not
   // an explicit green or yellow shows red, so illegal codes are all-red.
   always_comb begin
      NS_green    = (state == NS_GRN);
      NS_yellow   = (state == NS_YEL);
      NS_red      = !(NS_green || NS_yellow);
      EW_green    = (state == EW_GRN);
      EW_yellow   = (state == EW_YEL);
      EW_red      = !(EW_green || EW_yellow);
      walk_NS     = served_NS && (state == EW_GRN);
      walk_EW     = served_EW && (state == NS_GRN);
      ped_wait_NS = ped_pend_NS && NS_green && blink;
      ped_wait_EW = ped_pend_EW && EW_green && blink;
      phase       = state;
   end

endmodule
